// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: NUM_PORTS requesters share one single-ported memory.
// Define MEM_ARB_TIMEOUT_EN to abort stalled accesses and pulse port_err.
module mem_arbiter_rr #(
    parameter int NUM_PORTS      = 9,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             port_req,
    input  logic [NUM_PORTS-1:0]             port_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
    output logic [NUM_PORTS-1:0]             port_ack,
    output logic [DATA_WIDTH-1:0]            port_rdata,
    output logic [NUM_PORTS-1:0]             port_err,
    output logic                             mem_sel,
    output logic                             mem_w,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_ready
);

    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    if (NUM_PORTS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter_rr: bad NUM_PORTS or TIMEOUT_CYCLES");
    end

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   sel;
    logic            hit;

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addr_a[i]  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_PORTS
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        hit  = 1'b0;
        sel  = '0;
        idx  = 0;
        cand = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = PW'(idx);
            if (!hit && port_req[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`else
    assign port_err = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            port_ack   <= '0;
            port_rdata <= '0;
            mem_sel    <= 1'b0;
            mem_w      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            port_err   <= '0;
            wait_cnt   <= '0;
`endif
        end else begin
            port_ack <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            port_err <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        gnt       <= sel;
                        mem_sel   <= 1'b1;
                        mem_w     <= port_we[sel];
                        mem_addr  <= addr_a[sel];
                        mem_wdata <= wdata_a[sel];
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_w) port_rdata <= mem_rdata;
                        mem_sel       <= 1'b0;
                        mem_w         <= 1'b0;
                        port_ack[gnt] <= 1'b1;
                        state         <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        mem_sel       <= 1'b0;
                        mem_w         <= 1'b0;
                        port_err[gnt] <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                DONE: begin
                    if (gnt == PW'(NUM_PORTS - 1)) rr_ptr <= '0;
                    else rr_ptr <= gnt + PW'(1);
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
